// File: rtl/fejkon_data_tx_packer.sv
// Round-robin packer: collects whole packets from up to four 32-bit Avalon-ST
// channels and emits 256-bit beats (8 words) tagged with the source channel.
module fejkon_data_tx_packer #(
  parameter int NUM_CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CHANNELS*32-1:0] in_data,
  input  logic [NUM_CHANNELS-1:0]   in_valid,
  output logic [NUM_CHANNELS-1:0]   in_ready,
  input  logic [NUM_CHANNELS-1:0]   in_startofpacket,
  input  logic [NUM_CHANNELS-1:0]   in_endofpacket,
  input  logic [NUM_CHANNELS*2-1:0] in_empty,
  output logic [255:0]              out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [1:0]                out_channel,
  output logic                      out_startofpacket,
  output logic                      out_endofpacket,
  output logic [4:0]                out_empty,
  output logic [15:0]               drop_count
);

  typedef enum logic [1:0] {IDLE, PACK, SEND} state_t;

  state_t                  r_state, w_state_nxt;
  logic [1:0]              r_last, r_grant, w_grant;
  logic                    w_grant_vld;
  logic [2:0]              r_cnt;
  logic                    r_sop_pend;
  logic [31:0]             w_word;
  logic                    w_valid, w_eop;
  logic [1:0]              w_empty;
  logic                    w_accept, w_beat_full;
  logic [NUM_CHANNELS-1:0] w_drop_hit;
  logic [2:0]              w_drops;
  logic [16:0]             w_drop_sum;
  logic [4:0]              w_last_empty;

  // Rotating priority: first pass looks above the last winner, second wraps.
  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (!w_grant_vld && in_valid[i] && in_startofpacket[i] && (i > int'(r_last))) begin
        w_grant_vld = 1'b1;
        w_grant     = 2'(i);
      end
    end
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (!w_grant_vld && in_valid[i] && in_startofpacket[i]) begin
        w_grant_vld = 1'b1;
        w_grant     = 2'(i);
      end
    end
  end

  always_comb begin
    w_word     = '0;
    w_valid    = 1'b0;
    w_eop      = 1'b0;
    w_empty    = '0;
    in_ready   = '0;
    w_drop_hit = '0;
    w_drops    = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (r_grant == 2'(i)) begin
        w_word  = in_data[i*32 +: 32];
        w_valid = in_valid[i];
        w_eop   = in_endofpacket[i];
        w_empty = in_empty[i*2 +: 2];
      end
      w_drop_hit[i] = (r_state == IDLE) && in_valid[i] && !in_startofpacket[i];
      in_ready[i]   = w_drop_hit[i] || ((r_state == PACK) && (r_grant == 2'(i)));
      w_drops       = w_drops + {2'b00, w_drop_hit[i]};
    end
  end

  assign w_accept     = (r_state == PACK) && w_valid;
  assign w_beat_full  = (r_cnt == 3'd7) || w_eop;
  assign w_last_empty = {3'd7 - r_cnt, 2'b00} + {3'b000, w_empty};
  assign w_drop_sum   = {1'b0, drop_count} + {14'd0, w_drops};
  assign out_valid    = (r_state == SEND);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant_vld) w_state_nxt = PACK;
      PACK:    if (w_accept && w_beat_full) w_state_nxt = SEND;
      SEND:    if (out_ready) w_state_nxt = out_endofpacket ? IDLE : PACK;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state           <= IDLE;
      r_last            <= 2'(NUM_CHANNELS - 1);
      r_grant           <= '0;
      r_cnt             <= '0;
      r_sop_pend        <= 1'b0;
      out_data          <= '0;
      out_channel       <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_empty         <= '0;
      drop_count        <= '0;
    end else begin
      r_state    <= w_state_nxt;
      drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      case (r_state)
        IDLE: begin
          if (w_grant_vld) begin
            r_grant    <= w_grant;
            r_cnt      <= '0;
            r_sop_pend <= 1'b1;
          end
        end
        PACK: begin
          if (w_accept) begin
            out_data[{r_cnt, 5'b00000} +: 32] <= w_word;
            r_cnt <= r_cnt + 3'd1;
            if (w_beat_full) begin
              out_channel       <= r_grant;
              out_startofpacket <= r_sop_pend;
              out_endofpacket   <= w_eop;
              out_empty         <= w_eop ? w_last_empty : 5'd0;
              r_sop_pend        <= 1'b0;
            end
          end
        end
        SEND: begin
          // Clearing the beat here keeps unfilled slots of the next beat at zero.
          if (out_ready) begin
            r_cnt             <= '0;
            out_data          <= '0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_empty         <= '0;
            if (out_endofpacket) r_last <= r_grant;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
